// File: rtl/serial_word_assembler.sv
// Reassembles lane-tagged bytes into 32-bit words, buffers them in a small FIFO,
// and tracks per-frame word count, checksum and sticky error flags.
module serial_word_assembler #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_words,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  input  logic [1:0]       i_byte_idx,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [LEN_W-1:0] o_word_count,
  output logic [31:0]      o_checksum,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_overflow,
  output logic             o_order_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_len, r_count, w_count_inc;
  logic [1:0]       r_lane;
  logic [23:0]      r_part;
  logic [31:0]      r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic [31:0]      r_sum, w_word;
  logic             r_ovf, r_oerr;
  logic             w_empty, w_full, w_pop, w_start, w_take, w_in_order;
  logic             w_complete, w_push, w_drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr == r_rd);
  assign w_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop       = !w_empty && i_word_ready;
  assign w_start     = (r_state == S_IDLE) && i_start && (i_frame_words != '0);
  assign w_take      = (r_state == S_COLLECT) && i_byte_valid;
  assign w_in_order  = (i_byte_idx == r_lane);
  assign w_complete  = w_take && w_in_order && (r_lane == 2'd3);
  assign w_word      = {i_byte, r_part};
  assign w_push      = w_complete && (!w_full || w_pop);
  assign w_drop      = w_complete && w_full && !w_pop;
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_COLLECT;
      S_COLLECT: if (w_complete && (w_count_inc == r_len)) w_next = S_DRAIN;
      S_DRAIN:   if (w_empty) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_len   <= '0;
      r_count <= '0;
      r_lane  <= 2'd0;
      r_part  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      if (w_start) begin
        r_len   <= i_frame_words;
        r_count <= '0;
        r_sum   <= '0;
        r_lane  <= 2'd0;
        r_part  <= '0;
        r_ovf   <= 1'b0;
        r_oerr  <= 1'b0;
      end
      if (w_take) begin
        if (w_in_order) begin
          case (r_lane)
            2'd0:    r_part[7:0]   <= i_byte;
            2'd1:    r_part[15:8]  <= i_byte;
            2'd2:    r_part[23:16] <= i_byte;
            default: ;
          endcase
          r_lane <= r_lane + 2'd1;
          if (w_complete) begin
            r_count <= w_count_inc;
            r_sum   <= r_sum + w_word;
          end
        end else begin
          // Out-of-sequence lane: drop the partial word; a lane-0 byte restarts one.
          r_oerr <= 1'b1;
          if (i_byte_idx == 2'd0) begin
            r_part[7:0] <= i_byte;
            r_lane      <= 2'd1;
          end else begin
            r_lane <= 2'd0;
          end
        end
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_push) r_wr  <= r_wr + 1'b1;
      if (w_pop)  r_rd  <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_word;
  end

  assign o_word       = w_empty ? 32'd0 : r_mem[r_rd[AW-1:0]];
  assign o_word_valid = !w_empty;
  assign o_word_count = r_count;
  assign o_checksum   = r_sum;
  assign o_busy       = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign o_frame_done = (r_state == S_DONE);
  assign o_overflow   = r_ovf;
  assign o_order_err  = r_oerr;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed scenarios for serial_word_assembler with hand-computed expectations.
module tb_serial_word_assembler;
  localparam int LEN_W = 6;

  logic             CLK, RESET, i_start, i_byte_valid, i_word_ready;
  logic [LEN_W-1:0] i_frame_words;
  logic [7:0]       i_byte;
  logic [1:0]       i_byte_idx;
  logic [31:0]      o_word, o_checksum;
  logic             o_word_valid, o_busy, o_frame_done, o_overflow, o_order_err;
  logic [LEN_W-1:0] o_word_count;

  int n_cmp = 0;
  int n_err = 0;

  // word k carries bytes 4k+1 .. 4k+4 on lanes 0..3
  logic [31:0] W [5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                         32'h100F0E0D, 32'h14131211};

  serial_word_assembler #(.DEPTH(4), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .i_start(i_start), .i_frame_words(i_frame_words),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .i_byte_idx(i_byte_idx),
    .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_word_count(o_word_count), .o_checksum(o_checksum), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overflow(o_overflow), .o_order_err(o_order_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] idx);
    i_byte = b; i_byte_idx = idx; i_byte_valid = 1'b1;
    cyc();
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int l = 0; l < 4; l++) send(w[8*l +: 8], 2'(l));
  endtask

  task automatic start(input logic [LEN_W-1:0] n);
    i_start = 1'b1; i_frame_words = n;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc(); cyc();
    n_cmp++;
    if ({o_word, o_word_valid, o_word_count, o_checksum, o_busy, o_frame_done, o_overflow, o_order_err} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got word=%h v=%b cnt=%0d sum=%h busy=%b done=%b", o_word, o_word_valid, o_word_count, o_checksum, o_busy, o_frame_done);
    end
    RESET = 1'b0;
    cyc();
    send_word(32'hA5A5A5A5);
    n_cmp++;
    if (o_word_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_ignore: got v=%b busy=%b want 0 0", o_word_valid, o_busy);
    end
  endtask

  task automatic test_basic();
    int done = 0;
    i_word_ready = 1'b1;
    start(6'd2);
    n_cmp++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", o_busy); end
    send(8'h11, 2'd0); send(8'h22, 2'd1); send(8'h33, 2'd2); send(8'h44, 2'd3);
    n_cmp++;
    if (o_word_valid !== 1'b1 || o_word !== 32'h44332211 || o_word_count !== 6'd1) begin
      n_err++; $display("FAIL basic_word0: got v=%b word=%h cnt=%0d want 1 44332211 1", o_word_valid, o_word, o_word_count);
    end
    send(8'h55, 2'd0); send(8'h66, 2'd1); send(8'h77, 2'd2); send(8'h88, 2'd3);
    n_cmp++;
    if (o_word !== 32'h88776655 || o_word_count !== 6'd2 || o_checksum !== 32'hCCAA8866) begin
      n_err++; $display("FAIL basic_word1: got word=%h cnt=%0d sum=%h want 88776655 2 ccaa8866", o_word, o_word_count, o_checksum);
    end
    for (int c = 0; c < 12; c++) begin if (o_frame_done) done++; cyc(); end
    n_cmp++;
    if (done != 1 || o_busy !== 1'b0 || o_word_count !== 6'd2 || o_checksum !== 32'hCCAA8866) begin
      n_err++; $display("FAIL basic_done: got pulses=%0d busy=%b cnt=%0d sum=%h want 1 0 2 ccaa8866", done, o_busy, o_word_count, o_checksum);
    end
  endtask

  task automatic test_checksum_wrap();
    int done = 0;
    i_word_ready = 1'b1;
    start(6'd2);
    send_word(32'hFFFFFFFF);
    send_word(32'h00000002);
    n_cmp++;
    if (o_checksum !== 32'h00000001 || o_word_count !== 6'd2) begin
      n_err++; $display("FAIL checksum_wrap: got sum=%h cnt=%0d want 00000001 2", o_checksum, o_word_count);
    end
    for (int c = 0; c < 12; c++) begin if (o_frame_done) done++; cyc(); end
    n_cmp++;
    if (done != 1) begin n_err++; $display("FAIL wrap_done: got %0d pulses want 1", done); end
  endtask

  task automatic test_overflow();
    int idx = 0;
    int done = 0;
    i_word_ready = 1'b0;
    start(6'd5);
    for (int k = 0; k < 4; k++) send_word(W[k]);
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
    send_word(W[4]);
    n_cmp++;
    if (o_overflow !== 1'b1 || o_word_count !== 6'd5 || o_checksum !== 32'h3C37322D || o_word !== W[0]) begin
      n_err++; $display("FAIL ovf_set: got ovf=%b cnt=%0d sum=%h word=%h want 1 5 3c37322d %h", o_overflow, o_word_count, o_checksum, o_word, W[0]);
    end
    cyc(); cyc();
    n_cmp++;
    if (o_word !== W[0] || o_busy !== 1'b1) begin
      n_err++; $display("FAIL ovf_hold: got word=%h busy=%b want %h 1", o_word, o_busy, W[0]);
    end
    i_word_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (o_word_valid) begin
        n_cmp++;
        if (idx >= 4 || o_word !== W[idx]) begin
          n_err++; $display("FAIL ovf_drain[%0d]: got %h want %h", idx, o_word, W[idx % 5]);
        end
        idx++;
      end
      if (o_frame_done) done++;
      cyc();
    end
    n_cmp++;
    if (idx != 4 || done != 1) begin
      n_err++; $display("FAIL ovf_drain_count: got words=%0d pulses=%0d want 4 1", idx, done);
    end
  endtask

  task automatic test_order_err();
    int done = 0;
    int seen = 0;
    i_word_ready = 1'b1;
    start(6'd1);
    n_cmp++;
    if (o_overflow !== 1'b0 || o_order_err !== 1'b0) begin
      n_err++; $display("FAIL start_clears: got ovf=%b oerr=%b want 0 0", o_overflow, o_order_err);
    end
    send(8'hAA, 2'd0); send(8'hBB, 2'd1); send(8'hCC, 2'd3);
    n_cmp++;
    if (o_order_err !== 1'b1 || o_word_valid !== 1'b0) begin
      n_err++; $display("FAIL order_flag: got oerr=%b v=%b want 1 0", o_order_err, o_word_valid);
    end
    send(8'h01, 2'd0); send(8'h02, 2'd1); send(8'h03, 2'd2); send(8'h04, 2'd3);
    n_cmp++;
    if (o_word !== 32'h04030201 || o_word_count !== 6'd1) begin
      n_err++; $display("FAIL order_word: got word=%h cnt=%0d want 04030201 1", o_word, o_word_count);
    end
    for (int c = 0; c < 12; c++) begin
      if (o_word_valid) seen++;
      if (o_frame_done) done++;
      cyc();
    end
    n_cmp++;
    if (seen != 1 || done != 1 || o_order_err !== 1'b1) begin
      n_err++; $display("FAIL order_only_one: got words=%0d pulses=%0d oerr=%b want 1 1 1", seen, done, o_order_err);
    end
    // A mismatching lane-0 byte starts a fresh word.
    start(6'd1);
    n_cmp++;
    if (o_order_err !== 1'b0) begin n_err++; $display("FAIL restart_clear: got %b want 0", o_order_err); end
    send(8'hEE, 2'd0); send(8'h11, 2'd0); send(8'h22, 2'd1); send(8'h33, 2'd2); send(8'h44, 2'd3);
    n_cmp++;
    if (o_order_err !== 1'b1 || o_word !== 32'h44332211) begin
      n_err++; $display("FAIL order_relane0: got oerr=%b word=%h want 1 44332211", o_order_err, o_word);
    end
    done = 0;
    for (int c = 0; c < 12; c++) begin if (o_frame_done) done++; cyc(); end
    n_cmp++;
    if (done != 1) begin n_err++; $display("FAIL relane0_done: got %0d pulses want 1", done); end
  endtask

  task automatic test_zero_len();
    start(6'd0);
    n_cmp++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", o_busy); end
    send_word(32'hDEADBEEF);
    n_cmp++;
    if (o_word_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL zero_bytes: got v=%b busy=%b want 0 0", o_word_valid, o_busy);
    end
  endtask

  task automatic test_full_push_pop();
    int idx = 1;
    int done = 0;
    i_word_ready = 1'b0;
    start(6'd5);
    for (int k = 0; k < 4; k++) send_word(W[k]);
    send(8'h11, 2'd0); send(8'h12, 2'd1); send(8'h13, 2'd2);
    i_word_ready = 1'b1;
    send(8'h14, 2'd3);
    n_cmp++;
    if (o_overflow !== 1'b0 || o_word !== W[1]) begin
      n_err++; $display("FAIL pushpop: got ovf=%b word=%h want 0 %h", o_overflow, o_word, W[1]);
    end
    for (int c = 0; c < 16; c++) begin
      if (o_word_valid) begin
        n_cmp++;
        if (idx >= 5 || o_word !== W[idx]) begin
          n_err++; $display("FAIL pushpop_drain[%0d]: got %h want %h", idx, o_word, W[idx % 5]);
        end
        idx++;
      end
      if (o_frame_done) done++;
      cyc();
    end
    n_cmp++;
    if (idx != 5 || done != 1) begin
      n_err++; $display("FAIL pushpop_count: got words=%0d pulses=%0d want 4 1", idx - 1, done);
    end
  endtask

  task automatic test_reset_midframe();
    int done = 0;
    i_word_ready = 1'b0;
    start(6'd3);
    send_word(32'h12345678);
    send(8'hAA, 2'd0); send(8'hBB, 2'd1);
    n_cmp++;
    if (o_busy !== 1'b1 || o_word_valid !== 1'b1 || o_checksum !== 32'h12345678) begin
      n_err++; $display("FAIL mid_pre: got busy=%b v=%b sum=%h want 1 1 12345678", o_busy, o_word_valid, o_checksum);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({o_word, o_word_valid, o_word_count, o_checksum, o_busy, o_frame_done, o_overflow, o_order_err} !== '0) begin
      n_err++; $display("FAIL mid_async: got word=%h v=%b cnt=%0d sum=%h busy=%b", o_word, o_word_valid, o_word_count, o_checksum, o_busy);
    end
    cyc();
    RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin if (o_frame_done) done++; cyc(); end
    send(8'hCC, 2'd2); send(8'hDD, 2'd3);
    send_word(32'h01020304);
    n_cmp++;
    if (done != 0 || o_word_valid !== 1'b0 || o_busy !== 1'b0 || o_word_count !== '0) begin
      n_err++; $display("FAIL mid_after: got pulses=%0d v=%b busy=%b cnt=%0d want 0 0 0 0", done, o_word_valid, o_busy, o_word_count);
    end
  endtask

  initial begin
    RESET = 1'b1; i_start = 1'b0; i_frame_words = '0; i_byte = '0;
    i_byte_valid = 1'b0; i_byte_idx = '0; i_word_ready = 1'b0;
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_overflow();
    test_order_err();
    test_zero_len();
    test_full_push_pop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
